combination_grouper: RTL and testbench

COMBINATION_GROUPER -- requirements
Module: combination_grouper

---
 rtl/combination_pkg.sv | 23 ++
 rtl/combination_lane_step.sv | 54 +++++
 rtl/combination_grouper.sv | 167 ++++++++++++++++
 tb/tb_combination_grouper.sv | 358 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/combination_pkg.sv
// Shared types and derived widths for the combination grouper.
package combination_pkg;

  localparam int unsigned DefWidth        = 64;
  localparam int unsigned DefChannelWidth = 4;
  localparam int unsigned DefCountWidth   = 8;

  // One mask bit per virtual channel.
  function automatic int unsigned mask_w(input int unsigned channel_width);
    return 32'd1 << channel_width;
  endfunction

  localparam int unsigned DefMaskW = mask_w(DefChannelWidth);

  // Open-group state layout for the default configuration.
  typedef struct packed {
    logic                     open;
    logic [DefWidth-1:0]      start;
    logic [DefMaskW-1:0]      mask;
    logic [DefCountWidth-1:0] count;
  } group_state_t;

endpackage

// File: rtl/combination_lane_step.sv
// One tag's join/emit decision against the running group state; purely combinational.
// The emitted group, when emit is high, is the incoming state (in_*).
module combination_lane_step
  import combination_pkg::*;
#(
  parameter int unsigned WIDTH         = 64,
  parameter int unsigned CHANNEL_WIDTH = 4,
  parameter int unsigned COUNT_WIDTH   = 8,
  localparam int unsigned MASK_W       = mask_w(CHANNEL_WIDTH)
) (
  input  logic                     keep,
  input  logic [WIDTH-1:0]         tagtime,
  input  logic [CHANNEL_WIDTH-1:0] channel,
  input  logic [WIDTH-1:0]         window,
  input  logic                     in_open,
  input  logic [WIDTH-1:0]         in_start,
  input  logic [MASK_W-1:0]        in_mask,
  input  logic [COUNT_WIDTH-1:0]   in_count,
  output logic                     out_open,
  output logic [WIDTH-1:0]         out_start,
  output logic [MASK_W-1:0]        out_mask,
  output logic [COUNT_WIDTH-1:0]   out_count,
  output logic                     emit
);

  logic [WIDTH-1:0]  delta;
  logic [MASK_W-1:0] onehot;
  logic              joins;

  // Join the open group or close it and start a new one; unkept lanes pass through.
  always_comb begin
    delta     = tagtime - in_start;  // wraps modulo 2**WIDTH
    onehot    = MASK_W'(1) << channel;
    joins     = in_open && (delta <= window);
    out_open  = in_open;
    out_start = in_start;
    out_mask  = in_mask;
    out_count = in_count;
    emit      = 1'b0;
    if (keep) begin
      if (joins) begin
        out_mask  = in_mask | onehot;
        out_count = (in_count == {COUNT_WIDTH{1'b1}}) ? in_count : in_count + COUNT_WIDTH'(1);
      end else begin
        emit      = in_open;
        out_open  = 1'b1;
        out_start = tagtime;
        out_mask  = onehot;
        out_count = COUNT_WIDTH'(1);
      end
    end
  end

endmodule

// File: rtl/combination_grouper.sv
// Groups tag timestamps within a window per beat and emits closed groups on a registered stream.
module combination_grouper
  import combination_pkg::*;
#(
  parameter int unsigned WIDTH         = 64,
  parameter int unsigned LANE          = 4,
  parameter int unsigned CHANNEL_WIDTH = 4,
  parameter int unsigned COUNT_WIDTH   = 8,
  localparam int unsigned MASK_W       = mask_w(CHANNEL_WIDTH)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          s_axis_tvalid,
  output logic                          s_axis_tready,
  input  logic [LANE-1:0]               s_axis_tkeep,
  input  logic [WIDTH*LANE-1:0]         s_axis_tagtime,
  input  logic [CHANNEL_WIDTH*LANE-1:0] s_axis_channel,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic [LANE-1:0]               m_axis_tkeep,
  output logic [WIDTH*LANE-1:0]         m_axis_start,
  output logic [MASK_W*LANE-1:0]        m_axis_mask,
  output logic [COUNT_WIDTH*LANE-1:0]   m_axis_count,
  input  logic [WIDTH-1:0]              window,
  input  logic                          flush_req,
  output logic                          flush_done
);

  // Group state
  logic                   open_q, open_d;
  logic [WIDTH-1:0]       start_q, start_d;
  logic [MASK_W-1:0]      mask_q, mask_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d;

  // Output register
  logic                        tvalid_q, tvalid_d;
  logic [LANE-1:0]             tkeep_q, tkeep_d;
  logic [WIDTH*LANE-1:0]       ostart_q, ostart_d;
  logic [MASK_W*LANE-1:0]      omask_q, omask_d;
  logic [COUNT_WIDTH*LANE-1:0] ocount_q, ocount_d;
  logic                        flush_done_q, flush_done_d;
  logic                        flush_armed_q, flush_armed_d;

  // Lane chain: entry i is the state seen by lane i, entry LANE the state after the beat.
  logic [LANE:0]                  c_open;
  logic [LANE:0][WIDTH-1:0]       c_start;
  logic [LANE:0][MASK_W-1:0]      c_mask;
  logic [LANE:0][COUNT_WIDTH-1:0] c_count;
  logic [LANE-1:0]                emit;

  logic load, accept, flush_svc;

  assign c_open[0]  = open_q;
  assign c_start[0] = start_q;
  assign c_mask[0]  = mask_q;
  assign c_count[0] = count_q;

  for (genvar i = 0; i < LANE; i++) begin : g_lane
    combination_lane_step #(
      .WIDTH        (WIDTH),
      .CHANNEL_WIDTH(CHANNEL_WIDTH),
      .COUNT_WIDTH  (COUNT_WIDTH)
    ) u_step (
      .keep     (s_axis_tkeep[i]),
      .tagtime  (s_axis_tagtime[i*WIDTH +: WIDTH]),
      .channel  (s_axis_channel[i*CHANNEL_WIDTH +: CHANNEL_WIDTH]),
      .window   (window),
      .in_open  (c_open[i]),
      .in_start (c_start[i]),
      .in_mask  (c_mask[i]),
      .in_count (c_count[i]),
      .out_open (c_open[i+1]),
      .out_start(c_start[i+1]),
      .out_mask (c_mask[i+1]),
      .out_count(c_count[i+1]),
      .emit     (emit[i])
    );
  end

  // Ready is forced high while in reset so upstream never sees a stale stall.
  assign s_axis_tready = !rst_n || m_axis_tready || !tvalid_q;
  assign load          = rst_n && s_axis_tready;
  assign accept        = load && s_axis_tvalid;
  assign flush_svc     = load && !s_axis_tvalid && flush_req && flush_armed_q;

  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tkeep  = tkeep_q;
  assign m_axis_start  = ostart_q;
  assign m_axis_mask   = omask_q;
  assign m_axis_count  = ocount_q;
  assign flush_done    = flush_done_q;

  // Next state: beats win over flush; everything holds while the output is stalled.
  always_comb begin
    open_d        = open_q;
    start_d       = start_q;
    mask_d        = mask_q;
    count_d       = count_q;
    tvalid_d      = tvalid_q;
    tkeep_d       = tkeep_q;
    ostart_d      = ostart_q;
    omask_d       = omask_q;
    ocount_d      = ocount_q;
    flush_done_d  = 1'b0;
    flush_armed_d = flush_armed_q;
    // A fresh flush service needs flush_req to have dropped for at least one cycle.
    if (!flush_req) flush_armed_d = 1'b1;
    if (accept) begin
      open_d   = c_open[LANE];
      start_d  = c_start[LANE];
      mask_d   = c_mask[LANE];
      count_d  = c_count[LANE];
      tvalid_d = |emit;
      tkeep_d  = emit;
      for (int unsigned i = 0; i < LANE; i++) begin
        ostart_d[i*WIDTH +: WIDTH]             = c_start[i];
        omask_d[i*MASK_W +: MASK_W]            = c_mask[i];
        ocount_d[i*COUNT_WIDTH +: COUNT_WIDTH] = c_count[i];
      end
    end else if (load) begin
      tvalid_d = 1'b0;
      tkeep_d  = '0;
      if (flush_svc) begin
        flush_armed_d = 1'b0;
        flush_done_d  = 1'b1;
        if (open_q) begin
          tvalid_d                 = 1'b1;
          tkeep_d                  = LANE'(1);
          ostart_d[WIDTH-1:0]      = start_q;
          omask_d[MASK_W-1:0]      = mask_q;
          ocount_d[COUNT_WIDTH-1:0] = count_q;
          open_d                   = 1'b0;
        end
      end
    end
  end

  // Control state with synchronous active-low reset; an open group is dropped silently.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      open_q        <= 1'b0;
      mask_q        <= '0;
      count_q       <= '0;
      tvalid_q      <= 1'b0;
      tkeep_q       <= '0;
      flush_done_q  <= 1'b0;
      flush_armed_q <= 1'b1;
    end else begin
      open_q        <= open_d;
      mask_q        <= mask_d;
      count_q       <= count_d;
      tvalid_q      <= tvalid_d;
      tkeep_q       <= tkeep_d;
      flush_done_q  <= flush_done_d;
      flush_armed_q <= flush_armed_d;
    end
  end

  // Data registers carry no reset; they are qualified by open_q / tkeep_q.
  always_ff @(posedge clk) begin
    start_q  <= start_d;
    ostart_q <= ostart_d;
    omask_q  <= omask_d;
    ocount_q <= ocount_d;
  end

endmodule

// File: tb/tb_combination_grouper.sv
// Self-checking bench: directed vector table, hand-written stall/saturation sequences,
// and random beats scored against a tag-by-tag grouping model.
module tb_combination_grouper;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_n = 1'b0;
  logic             s_tvalid = 1'b0;
  logic             s_tready, s_tready2;
  logic [3:0]       s_keep = '0;
  logic [3:0][63:0] s_time = '0;
  logic [3:0][3:0]  s_ch = '0;
  logic             m_tready = 1'b1;
  logic             m_tvalid, m_tvalid2;
  logic [3:0]       m_tkeep, m_tkeep2;
  logic [3:0][63:0] m_start, m_start2;
  logic [3:0][15:0] m_mask, m_mask2;
  logic [3:0][7:0]  m_count;
  logic [3:0][1:0]  m_count2;
  logic [63:0]      window = 64'd10;
  logic             flush_req = 1'b0;
  logic             flush_done, flush_done2;

  combination_grouper #(.WIDTH(64), .LANE(4), .CHANNEL_WIDTH(4), .COUNT_WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready),
    .s_axis_tkeep(s_keep), .s_axis_tagtime(s_time), .s_axis_channel(s_ch),
    .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready), .m_axis_tkeep(m_tkeep),
    .m_axis_start(m_start), .m_axis_mask(m_mask), .m_axis_count(m_count),
    .window(window), .flush_req(flush_req), .flush_done(flush_done)
  );

  // Narrow-count twin fed the same stream, used for the saturation case.
  combination_grouper #(.WIDTH(64), .LANE(4), .CHANNEL_WIDTH(4), .COUNT_WIDTH(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready2),
    .s_axis_tkeep(s_keep), .s_axis_tagtime(s_time), .s_axis_channel(s_ch),
    .m_axis_tvalid(m_tvalid2), .m_axis_tready(m_tready), .m_axis_tkeep(m_tkeep2),
    .m_axis_start(m_start2), .m_axis_mask(m_mask2), .m_axis_count(m_count2),
    .window(window), .flush_req(flush_req), .flush_done(flush_done2)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit               rst;
    logic [63:0]      win;
    bit               fl;
    logic [3:0]       keep;
    logic [3:0][63:0] t;
    logic [3:0][3:0]  ch;
    logic [3:0]       ekeep;
    logic [3:0][63:0] es;
    logic [3:0][15:0] em;
    logic [3:0][7:0]  ec;
    bit               efd;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(bit rst, logic [63:0] win, bit fl, logic [3:0] keep,
                              logic [255:0] t, logic [15:0] ch, logic [3:0] ekeep,
                              logic [255:0] es, logic [63:0] em, logic [31:0] ec, bit efd);
    vec_t v;
    v.rst = rst; v.win = win; v.fl = fl; v.keep = keep; v.t = t; v.ch = ch;
    v.ekeep = ekeep; v.es = es; v.em = em; v.ec = ec; v.efd = efd;
    return v;
  endfunction

  // ---------------- reference model ----------------
  typedef struct {
    logic [3:0]       keep;
    logic [3:0][63:0] s;
    logic [3:0][15:0] m;
    logic [3:0][7:0]  c;
  } exp_t;

  exp_t        q[$];
  bit          mo = 1'b0;
  logic [63:0] ms = '0;
  logic [15:0] mm = '0;
  int          mc = 0;
  int          fd_exp = 0;
  int          fd_seen = 0;
  bit          sb_on = 1'b0;
  bit          rdy_rand = 1'b0;

  task automatic model_beat(input logic [3:0] keep, input logic [3:0][63:0] t,
                            input logic [3:0][3:0] ch);
    exp_t        e;
    logic [63:0] d;
    e.keep = '0; e.s = '0; e.m = '0; e.c = '0;
    for (int i = 0; i < 4; i++) begin
      if (keep[i]) begin
        d = t[i] - ms;
        if (mo && d <= window) begin
          mm = mm | (16'(1) << ch[i]);
          if (mc < 255) mc++;
        end else begin
          if (mo) begin
            e.keep[i] = 1'b1; e.s[i] = ms; e.m[i] = mm; e.c[i] = 8'(mc);
          end
          mo = 1'b1; ms = t[i]; mm = 16'(1) << ch[i]; mc = 1;
        end
      end
    end
    if (e.keep != 0) q.push_back(e);
  endtask

  task automatic model_flush();
    exp_t e;
    fd_exp++;
    if (mo) begin
      e.keep = 4'b0001; e.s = '0; e.m = '0; e.c = '0;
      e.s[0] = ms; e.m[0] = mm; e.c[0] = 8'(mc);
      q.push_back(e);
    end
    mo = 1'b0;
  endtask

  // ---------------- drivers (entered and left at 1 time unit after a rising edge) -------
  task automatic do_reset();
    rst_n = 1'b0; s_tvalid = 1'b0; flush_req = 1'b0;
    @(negedge clk);
    chk("tready_in_reset", s_tready, 1);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("reset_tvalid", m_tvalid, 0);
    chk("reset_tkeep", m_tkeep, 0);
    chk("reset_flush_done", flush_done, 0);
    @(posedge clk); #1;
  endtask

  task automatic send_beat(input logic [3:0] keep, input logic [3:0][63:0] t,
                           input logic [3:0][3:0] ch);
    int n = 0;
    s_tvalid = 1'b1; s_keep = keep; s_time = t; s_ch = ch;
    @(negedge clk);
    while (!s_tready && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (!s_tready) chk("send_timeout", s_tready, 1);
    else begin
      @(posedge clk);
      model_beat(keep, t, ch);
    end
    #1 s_tvalid = 1'b0; s_keep = '0;
  endtask

  task automatic do_flush();
    int n = 0;
    flush_req = 1'b1; s_tvalid = 1'b0;
    @(negedge clk);
    while (!s_tready && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (!s_tready) chk("flush_timeout", s_tready, 1);
    else begin
      @(posedge clk);
      model_flush();
    end
    #1 flush_req = 1'b0;
    @(posedge clk); #1;
  endtask

  // Random downstream back-pressure during the scoreboard phase.
  always @(posedge clk) begin
    #1;
    if (rdy_rand) m_tready = 1'($urandom_range(0, 1));
  end

  // Output scoreboard: a beat is consumed at the next rising edge.
  always @(negedge clk) begin
    if (sb_on) begin
      if (flush_done) fd_seen++;
      if (m_tvalid && m_tready) begin
        if (q.size() == 0) chk("sb_extra_beat_keep", m_tkeep, 0);
        else begin
          exp_t e;
          e = q.pop_front();
          chk("sb_keep", m_tkeep, e.keep);
          for (int i = 0; i < 4; i++) begin
            if (e.keep[i]) begin
              chk($sformatf("sb_start[%0d]", i), m_start[i], e.s[i]);
              chk($sformatf("sb_mask[%0d]", i), m_mask[i], e.m[i]);
              chk($sformatf("sb_count[%0d]", i), m_count[i], e.c[i]);
            end
          end
        end
      end
    end
  end

  logic [63:0] tt;
  logic [3:0][63:0] rt;
  logic [3:0][3:0]  rc;

  initial begin
    // Basic grouping, window 10
    vt.push_back(mk(1, 10, 0, 4'b0111, {64'd0, 64'd120, 64'd105, 64'd100}, {4'd0, 4'd3, 4'd2, 4'd1},
                    4'b0100, {64'd0, 64'd100, 64'd0, 64'd0}, {16'h0, 16'h6, 16'h0, 16'h0},
                    {8'd0, 8'd2, 8'd0, 8'd0}, 0));
    vt.push_back(mk(0, 10, 0, 4'b0001, {64'd0, 64'd0, 64'd0, 64'd200}, 16'h0000,
                    4'b0001, {192'd0, 64'd120}, {48'h0, 16'h8}, {24'd0, 8'd1}, 0));
    vt.push_back(mk(0, 10, 1, 4'b0000, 256'd0, 16'h0,
                    4'b0001, {192'd0, 64'd200}, {48'h0, 16'h1}, {24'd0, 8'd1}, 1));
    // Window 0: identical timestamps only
    vt.push_back(mk(1, 0, 0, 4'b0111, {64'd0, 64'd51, 64'd50, 64'd50}, {4'd0, 4'd6, 4'd5, 4'd4},
                    4'b0100, {64'd0, 64'd50, 64'd0, 64'd0}, {16'h0, 16'h30, 16'h0, 16'h0},
                    {8'd0, 8'd2, 8'd0, 8'd0}, 0));
    vt.push_back(mk(0, 0, 1, 4'b0000, 256'd0, 16'h0,
                    4'b0001, {192'd0, 64'd51}, {48'h0, 16'h40}, {24'd0, 8'd1}, 1));
    // Timestamp wrap: delta 7
    vt.push_back(mk(0, 10, 0, 4'b0001, {192'd0, 64'hFFFF_FFFF_FFFF_FFFC}, 16'h0001,
                    4'b0000, 256'd0, 64'd0, 32'd0, 0));
    vt.push_back(mk(0, 10, 0, 4'b0001, {192'd0, 64'd3}, 16'h0002,
                    4'b0000, 256'd0, 64'd0, 32'd0, 0));
    vt.push_back(mk(0, 10, 1, 4'b0000, 256'd0, 16'h0,
                    4'b0001, {192'd0, 64'hFFFF_FFFF_FFFF_FFFC}, {48'h0, 16'h6}, {24'd0, 8'd2}, 1));
    // Flush while closed: done pulse, no output
    vt.push_back(mk(0, 10, 1, 4'b0000, 256'd0, 16'h0, 4'b0000, 256'd0, 64'd0, 32'd0, 1));
    // Reset discards an open group
    vt.push_back(mk(0, 10, 0, 4'b0001, {192'd0, 64'd500}, 16'h0003,
                    4'b0000, 256'd0, 64'd0, 32'd0, 0));
    vt.push_back(mk(1, 10, 0, 4'b0001, {192'd0, 64'd1000}, 16'h0007,
                    4'b0000, 256'd0, 64'd0, 32'd0, 0));
    vt.push_back(mk(0, 10, 1, 4'b0000, 256'd0, 16'h0,
                    4'b0001, {192'd0, 64'd1000}, {48'h0, 16'h80}, {24'd0, 8'd1}, 0 | 1));
    // Sparse keep with junk in unkept lanes, then window edge (delta 10 joins, 11 closes)
    vt.push_back(mk(0, 10, 0, 4'b1010, {64'd2005, 64'd7, 64'd2000, 64'd9}, {4'd1, 4'd9, 4'd0, 4'd9},
                    4'b0000, 256'd0, 64'd0, 32'd0, 0));
    vt.push_back(mk(0, 10, 0, 4'b1111, {64'd3000, 64'd2011, 64'd2011, 64'd2010},
                    {4'd4, 4'd3, 4'd3, 4'd2}, 4'b1010,
                    {64'd2011, 64'd0, 64'd2000, 64'd0}, {16'h8, 16'h0, 16'h7, 16'h0},
                    {8'd2, 8'd0, 8'd3, 8'd0}, 0));
    vt.push_back(mk(0, 10, 1, 4'b0000, 256'd0, 16'h0,
                    4'b0001, {192'd0, 64'd3000}, {48'h0, 16'h10}, {24'd0, 8'd1}, 1));
    // All-ones window groups everything until flush
    vt.push_back(mk(0, 64'hFFFF_FFFF_FFFF_FFFF, 0, 4'b0011,
                    {128'd0, 64'd1000000000000000000, 64'd5}, 16'h0010,
                    4'b0000, 256'd0, 64'd0, 32'd0, 0));
    vt.push_back(mk(0, 64'hFFFF_FFFF_FFFF_FFFF, 1, 4'b0000, 256'd0, 16'h0,
                    4'b0001, {192'd0, 64'd5}, {48'h0, 16'h3}, {24'd0, 8'd2}, 1));

    @(posedge clk); #1;
    foreach (vt[k]) begin
      if (vt[k].rst) do_reset();
      window = vt[k].win;
      if (vt[k].fl) begin
        flush_req = 1'b1; s_tvalid = 1'b0;
      end else begin
        s_tvalid = 1'b1; s_keep = vt[k].keep; s_time = vt[k].t; s_ch = vt[k].ch;
      end
      @(posedge clk); #1 s_tvalid = 1'b0; flush_req = 1'b0; s_keep = '0;
      @(negedge clk);
      chk($sformatf("v%0d_tvalid", k), m_tvalid, 64'(|vt[k].ekeep));
      chk($sformatf("v%0d_tkeep", k), m_tkeep, vt[k].ekeep);
      chk($sformatf("v%0d_flush_done", k), flush_done, vt[k].efd);
      for (int i = 0; i < 4; i++) begin
        if (vt[k].ekeep[i]) begin
          chk($sformatf("v%0d_start[%0d]", k, i), m_start[i], vt[k].es[i]);
          chk($sformatf("v%0d_mask[%0d]", k, i), m_mask[i], vt[k].em[i]);
          chk($sformatf("v%0d_count[%0d]", k, i), m_count[i], vt[k].ec[i]);
        end
      end
      @(posedge clk); #1;
    end

    // Downstream stall for three cycles with a beat waiting upstream
    do_reset();
    window = 64'd10; m_tready = 1'b1;
    send_beat(4'b0001, {192'd0, 64'd100}, 16'h0001);
    send_beat(4'b0001, {192'd0, 64'd200}, 16'h0002);
    m_tready = 1'b0;
    s_tvalid = 1'b1; s_keep = 4'b0001; s_time = {192'd0, 64'd300}; s_ch = 16'h0003;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("stall_s_tready", s_tready, 0);
      chk("stall_tvalid", m_tvalid, 1);
      chk("stall_tkeep", m_tkeep, 4'b0001);
      chk("stall_start", m_start[0], 64'd100);
      chk("stall_mask", m_mask[0], 16'h2);
      chk("stall_count", m_count[0], 8'd1);
      if (c < 2) @(posedge clk);
    end
    @(posedge clk); #1 m_tready = 1'b1;
    @(negedge clk);
    chk("unstall_s_tready", s_tready, 1);
    @(posedge clk); #1 s_tvalid = 1'b0; s_keep = '0;
    @(negedge clk);
    chk("unstall_tkeep", m_tkeep, 4'b0001);
    chk("unstall_start", m_start[0], 64'd200);
    chk("unstall_mask", m_mask[0], 16'h4);
    @(posedge clk); #1 flush_req = 1'b1;
    @(posedge clk); #1 flush_req = 1'b0;
    @(negedge clk);
    chk("stall_flush_start", m_start[0], 64'd300);
    chk("stall_flush_mask", m_mask[0], 16'h8);
    chk("stall_flush_done", flush_done, 1);
    @(posedge clk); #1;

    // Count saturation: five tags in one group, 8-bit and 2-bit count instances
    do_reset();
    window = 64'd10;
    send_beat(4'b1111, {64'd13, 64'd12, 64'd11, 64'd10}, 16'h0000);
    send_beat(4'b0001, {192'd0, 64'd14}, 16'h0000);
    flush_req = 1'b1;
    @(posedge clk); #1 flush_req = 1'b0;
    @(negedge clk);
    chk("sat_start", m_start[0], 64'd10);
    chk("sat_count8", m_count[0], 8'd5);
    chk("sat_tkeep2", m_tkeep2, 4'b0001);
    chk("sat_count2", m_count2[0], 2'd3);
    chk("sat_mask2", m_mask2[0], 16'h1);
    @(posedge clk); #1;

    // Random beats with back-pressure against the model
    do_reset();
    mo = 1'b0; q.delete(); fd_exp = 0; fd_seen = 0;
    window = 64'($urandom_range(0, 12));
    tt = 64'hFFFF_FFFF_FFFF_FF00;
    sb_on = 1'b1; rdy_rand = 1'b1;
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 9) == 0) do_flush();
      else begin
        for (int i = 0; i < 4; i++) begin
          tt = tt + 64'($urandom_range(0, 6));
          rt[i] = tt;
          rc[i] = 4'($urandom_range(0, 15));
        end
        send_beat(4'($urandom_range(0, 15)), rt, rc);
      end
    end
    do_flush();
    rdy_rand = 1'b0;
    @(posedge clk); #1 m_tready = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("sb_drained", 64'(q.size()), 0);
    chk("sb_flush_done_count", 64'(fd_seen), 64'(fd_exp));
    sb_on = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
